// File: rtl/carfield_l2_port_arbiter.sv
// Arbitrates NumReq requesters onto the two windows of a dual-port L2.
// Address decode, per-port round-robin and per-port IDLE/REQ/WAIT sequencing.
module carfield_l2_port_arbiter #(
   parameter int unsigned          NumReq     = 2,
   parameter int unsigned          AddrWidth  = 48,
   parameter int unsigned          DataWidth  = 64,
   parameter logic [AddrWidth-1:0] L2Base     = 'h7800_0000,
   parameter logic [AddrWidth-1:0] L2PortSize = 'h0020_0000
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NumReq-1:0]                     req_valid_i,
   output logic [NumReq-1:0]                     req_ready_o,
   input  logic [NumReq-1:0][AddrWidth-1:0]      req_addr_i,
   input  logic [NumReq-1:0]                     req_we_i,
   input  logic [NumReq-1:0][DataWidth-1:0]      req_wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]    req_be_i,
   output logic [NumReq-1:0]                     rsp_valid_o,
   output logic [NumReq-1:0][DataWidth-1:0]      rsp_rdata_o,
   output logic [NumReq-1:0]                     rsp_err_o,
   output logic [1:0]                            port_req_o,
   input  logic [1:0]                            port_gnt_i,
   output logic [1:0][AddrWidth-1:0]             port_addr_o,
   output logic [1:0]                            port_we_o,
   output logic [1:0][DataWidth-1:0]             port_wdata_o,
   output logic [1:0][DataWidth/8-1:0]           port_be_o,
   input  logic [1:0]                            port_rvalid_i,
   input  logic [1:0][DataWidth-1:0]             port_rdata_i
);

   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned ExtWidth = AddrWidth + 2;

   // Window bounds widened by two bits so base + 2*size cannot wrap.
   localparam logic [ExtWidth-1:0]  Base0     = ExtWidth'(L2Base);
   localparam logic [ExtWidth-1:0]  Base1     = Base0 + ExtWidth'(L2PortSize);
   localparam logic [ExtWidth-1:0]  Limit     = Base1 + ExtWidth'(L2PortSize);
   localparam logic [AddrWidth-1:0] Port1Base = L2Base + L2PortSize;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } port_state_e;

   port_state_e                     state_q [2];
   port_state_e                     state_d [2];
   logic [1:0][IdxWidth-1:0]        ptr_q, ptr_d;
   logic [1:0][IdxWidth-1:0]        owner_q, owner_d;
   logic [NumReq-1:0]               busy_q, busy_d;

   logic [1:0]                      port_req_d;
   logic [1:0][AddrWidth-1:0]       port_addr_q, port_addr_d;
   logic [1:0]                      port_we_q, port_we_d;
   logic [1:0][DataWidth-1:0]       port_wdata_q, port_wdata_d;
   logic [1:0][BeWidth-1:0]         port_be_q, port_be_d;

   logic [NumReq-1:0]               rsp_valid_q, rsp_valid_d;
   logic [NumReq-1:0][DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [NumReq-1:0]               rsp_err_q, rsp_err_d;

   logic [1:0][NumReq-1:0]          hit;
   logic [NumReq-1:0]               dec_err;

   // Unsigned window decode per requester.
   always_comb begin
      hit     = '0;
      dec_err = '0;
      for (int i = 0; i < NumReq; i++) begin
         hit[0][i]  = (ExtWidth'(req_addr_i[i]) >= Base0) && (ExtWidth'(req_addr_i[i]) < Base1);
         hit[1][i]  = (ExtWidth'(req_addr_i[i]) >= Base1) && (ExtWidth'(req_addr_i[i]) < Limit);
         dec_err[i] = !(hit[0][i] || hit[1][i]);
      end
   end

   // Next-state: port FSMs, arbitration, busy tracking and responses.
   always_comb begin
      logic                found;
      logic [IdxWidth-1:0] sel;

      found        = 1'b0;
      sel          = '0;
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      busy_d       = busy_q;
      port_addr_d  = port_addr_q;
      port_we_d    = port_we_q;
      port_wdata_d = port_wdata_q;
      port_be_d    = port_be_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = '0;
      rsp_err_d    = '0;
      req_ready_o  = '0;

      for (int p = 0; p < 2; p++) begin
         unique case (state_q[p])
            IDLE: begin
               found = 1'b0;
               for (int unsigned k = 0; k < NumReq; k++) begin
                  sel = IdxWidth'((32'(ptr_q[p]) + k) % NumReq);
                  if (!found && req_valid_i[sel] && !busy_q[sel] && hit[p][sel]) begin
                     found           = 1'b1;
                     req_ready_o[sel] = 1'b1;
                     busy_d[sel]     = 1'b1;
                     owner_d[p]      = sel;
                     ptr_d[p]        = IdxWidth'((32'(sel) + 1) % NumReq);
                     state_d[p]      = REQ;
                     port_addr_d[p]  = req_addr_i[sel] - ((p == 0) ? L2Base : Port1Base);
                     port_we_d[p]    = req_we_i[sel];
                     port_wdata_d[p] = req_wdata_i[sel];
                     port_be_d[p]    = req_be_i[sel];
                  end
               end
            end
            REQ: begin
               if (port_gnt_i[p]) state_d[p] = WAIT;
            end
            WAIT: begin
               if (port_rvalid_i[p]) begin
                  state_d[p]                = IDLE;
                  rsp_valid_d[owner_q[p]]   = 1'b1;
                  rsp_rdata_d[owner_q[p]]   = port_we_q[p] ? '0 : port_rdata_i[p];
                  busy_d[owner_q[p]]        = 1'b0;
               end
            end
            default: state_d[p] = IDLE;
         endcase
      end

      // Decode errors bypass arbitration and answer on the next cycle.
      for (int i = 0; i < NumReq; i++) begin
         if (req_valid_i[i] && !busy_q[i] && dec_err[i]) begin
            req_ready_o[i] = 1'b1;
            rsp_valid_d[i] = 1'b1;
            rsp_err_d[i]   = 1'b1;
         end
      end

      for (int p = 0; p < 2; p++) port_req_d[p] = (state_d[p] == REQ);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < 2; p++) state_q[p] <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         busy_q       <= '0;
         port_req_o   <= '0;
         port_addr_q  <= '0;
         port_we_q    <= '0;
         port_wdata_q <= '0;
         port_be_q    <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= '0;
      end else begin
         for (int p = 0; p < 2; p++) state_q[p] <= state_d[p];
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         busy_q       <= busy_d;
         port_req_o   <= port_req_d;
         port_addr_q  <= port_addr_d;
         port_we_q    <= port_we_d;
         port_wdata_q <= port_wdata_d;
         port_be_q    <= port_be_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign port_addr_o  = port_addr_q;
   assign port_we_o    = port_we_q;
   assign port_wdata_o = port_wdata_q;
   assign port_be_o    = port_be_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_carfield_l2_port_arbiter.sv
// Bench for carfield_l2_port_arbiter: directed and randomized request rounds
// checked against a transaction-level decode/round-robin reference model.
module tb_carfield_l2_port_arbiter;

   localparam logic [47:0] L2Base     = 48'h7800_0000;
   localparam logic [47:0] L2PortSize = 48'h0020_0000;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic [1:0]           req_valid, req_ready, req_we;
   logic [1:0][47:0]     req_addr;
   logic [1:0][63:0]     req_wdata;
   logic [1:0][7:0]      req_be;
   logic [1:0]           rsp_valid, rsp_err;
   logic [1:0][63:0]     rsp_rdata;
   logic [1:0]           port_req, port_gnt, port_we, port_rvalid;
   logic [1:0][47:0]     port_addr;
   logic [1:0][63:0]     port_wdata, port_rdata;
   logic [1:0][7:0]      port_be;

   carfield_l2_port_arbiter dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_we_i     (req_we),
      .req_wdata_i  (req_wdata),
      .req_be_i     (req_be),
      .rsp_valid_o  (rsp_valid),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_err_o    (rsp_err),
      .port_req_o   (port_req),
      .port_gnt_i   (port_gnt),
      .port_addr_o  (port_addr),
      .port_we_o    (port_we),
      .port_wdata_o (port_wdata),
      .port_be_o    (port_be),
      .port_rvalid_i(port_rvalid),
      .port_rdata_i (port_rdata)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int ptr [2];

   // One round of stimulus: requests presented together, then each won port serviced.
   logic        r_valid [2];
   logic        r_we    [2];
   logic [47:0] r_addr  [2];
   logic [63:0] r_wdata [2];
   logic [7:0]  r_be    [2];
   logic [63:0] r_rdata [2];
   int          r_gdly  [2];
   int          r_rdly  [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode: 0 = port 0 window, 1 = port 1 window, 2 = error.
   function automatic int decode(input logic [47:0] a);
      longint unsigned x, b, s;
      x = longint'(a);
      b = longint'(L2Base);
      s = longint'(L2PortSize);
      if (x >= b && x < b + s)         return 0;
      if (x >= b + s && x < b + 2 * s) return 1;
      return 2;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [47:0] a, input logic we);
      r_valid[i] = v;
      r_addr[i]  = a;
      r_we[i]    = we;
      r_wdata[i] = {$urandom, $urandom};
      r_be[i]    = 8'($urandom);
      r_rdata[i] = {$urandom, $urandom};
      r_gdly[i]  = $urandom_range(0, 2);
      r_rdly[i]  = $urandom_range(0, 2);
   endtask

   task automatic run_round();
      int         win [2];
      logic [1:0] exp_ready, err_mask, exp_preq;
      logic [47:0] held;
      err_mask = '0;
      for (int p = 0; p < 2; p++) begin
         win[p] = -1;
         for (int k = 0; k < 2; k++) begin
            int i;
            i = (ptr[p] + k) % 2;
            if (win[p] < 0 && r_valid[i] && decode(r_addr[i]) == p) win[p] = i;
         end
      end
      for (int i = 0; i < 2; i++) if (r_valid[i] && decode(r_addr[i]) == 2) err_mask[i] = 1'b1;
      exp_ready = err_mask;
      exp_preq  = '0;
      for (int p = 0; p < 2; p++) if (win[p] >= 0) begin
         exp_ready[win[p]] = 1'b1;
         exp_preq[p]       = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = r_valid[i];
         req_addr[i]  = r_addr[i];
         req_we[i]    = r_we[i];
         req_wdata[i] = r_wdata[i];
         req_be[i]    = r_be[i];
      end
      #1 check("req_ready", 64'(req_ready), 64'(exp_ready));

      @(negedge clk);
      req_valid = '0;
      check("port_req_after_accept", 64'(port_req), 64'(exp_preq));
      check("err_rsp_valid", 64'(rsp_valid), 64'(err_mask));
      check("err_rsp_err", 64'(rsp_err), 64'(err_mask));
      for (int i = 0; i < 2; i++) if (err_mask[i]) check("err_rdata", rsp_rdata[i], 64'h0);

      for (int p = 0; p < 2; p++) if (win[p] >= 0) begin
         int w;
         w = win[p];
         check("port_addr", 64'(port_addr[p]), 64'(r_addr[w] - (L2Base + ((p == 1) ? L2PortSize : 48'h0))));
         check("port_we", 64'(port_we[p]), 64'(r_we[w]));
         check("port_wdata", port_wdata[p], r_wdata[w]);
         check("port_be", 64'(port_be[p]), 64'(r_be[w]));
         ptr[p] = (w + 1) % 2;
      end

      for (int p = 0; p < 2; p++) if (win[p] >= 0) begin
         int w;
         w    = win[p];
         held = port_addr[p];
         // While in REQ a stray rvalid must be ignored and the request held.
         repeat (r_gdly[p]) begin
            port_rvalid[p] = 1'b1;
            port_rdata[p]  = 64'hBAD0_BAD0;
            @(negedge clk);
            port_rvalid[p] = 1'b0;
            check("port_req_held", 64'(port_req[p]), 64'h1);
            check("port_addr_stable", 64'(port_addr[p]), 64'(held));
            check("no_rsp_in_req", 64'(rsp_valid), 64'h0);
         end
         port_gnt[p] = 1'b1;
         @(negedge clk);
         port_gnt[p] = 1'b0;
         check("port_req_drop_after_gnt", 64'(port_req[p]), 64'h0);
         repeat (r_rdly[p]) @(negedge clk);
         port_rvalid[p] = 1'b1;
         port_rdata[p]  = r_rdata[p];
         @(negedge clk);
         port_rvalid[p] = 1'b0;
         check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << w));
         check("rsp_rdata", rsp_rdata[w], r_we[w] ? 64'h0 : r_rdata[p]);
         check("rsp_err", 64'(rsp_err), 64'h0);
      end
      @(negedge clk);
   endtask

   function automatic logic [47:0] rand_addr();
      logic [47:0] edges [6];
      edges[0] = L2Base;
      edges[1] = L2Base + 2 * L2PortSize - 48'h8;
      edges[2] = L2Base + L2PortSize;
      edges[3] = L2Base - 48'h1;
      edges[4] = L2Base + 2 * L2PortSize;
      edges[5] = 48'h8000_0000;
      case ($urandom_range(0, 5))
         0, 1:    return L2Base + 48'($urandom_range(0, 32'h1F_FFFF) & 32'hFFFF_FFF8);
         2, 3:    return L2Base + L2PortSize + 48'($urandom_range(0, 32'h1F_FFFF) & 32'hFFFF_FFF8);
         default: return edges[$urandom_range(0, 5)];
      endcase
   endfunction

   initial begin
      rst_i       = 1'b1;
      req_valid   = '0;
      req_we      = '0;
      req_addr    = '0;
      req_wdata   = '0;
      req_be      = '0;
      port_gnt    = '0;
      port_rvalid = '0;
      port_rdata  = '0;
      ptr[0]      = 0;
      ptr[1]      = 0;
      repeat (3) @(negedge clk);
      check("reset_port_req", 64'(port_req), 64'h0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
      check("reset_rsp_err", 64'(rsp_err), 64'h0);
      check("reset_port_addr0", 64'(port_addr[0]), 64'h0);
      check("reset_rsp_rdata1", rsp_rdata[1], 64'h0);
      rst_i = 1'b0;
      @(negedge clk);

      // Single read on port 0 with immediate grant and rvalid two cycles later.
      set_req(0, 1'b1, 48'h7800_0010, 1'b0);
      set_req(1, 1'b0, 48'h0, 1'b0);
      r_gdly[0]  = 0;
      r_rdly[0]  = 1;
      r_rdata[0] = 64'hDEAD;
      run_round();

      // Write on port 1 only.
      set_req(0, 1'b0, 48'h0, 1'b0);
      set_req(1, 1'b1, 48'h7820_0008, 1'b1);
      run_round();

      // Contention on port 0, twice: pointer moves the win to the other requester.
      set_req(0, 1'b1, 48'h7800_0100, 1'b0);
      set_req(1, 1'b1, 48'h7800_0200, 1'b1);
      run_round();
      set_req(0, 1'b1, 48'h7800_0300, 1'b1);
      set_req(1, 1'b1, 48'h7800_0400, 1'b0);
      run_round();

      // Decode error.
      set_req(0, 1'b1, 48'h8000_0000, 1'b0);
      set_req(1, 1'b0, 48'h0, 1'b0);
      run_round();

      // Both ports accept in the same cycle.
      set_req(0, 1'b1, 48'h7800_0040, 1'b0);
      set_req(1, 1'b1, 48'h7820_0080, 1'b0);
      run_round();

      // Reset while port 0 is waiting for its response.
      req_valid[0] = 1'b1;
      req_addr[0]  = 48'h7800_1230;
      req_we[0]    = 1'b0;
      #1 check("pre_reset_ready", 64'(req_ready), 64'h1);
      @(negedge clk);
      req_valid   = '0;
      port_gnt[0] = 1'b1;
      @(negedge clk);
      port_gnt[0] = 1'b0;
      rst_i       = 1'b1;
      @(negedge clk);
      rst_i  = 1'b0;
      ptr[0] = 0;
      ptr[1] = 0;
      check("midrst_port_req", 64'(port_req), 64'h0);
      check("midrst_port_addr0", 64'(port_addr[0]), 64'h0);
      check("midrst_port_we0", 64'(port_we[0]), 64'h0);
      check("midrst_port_wdata0", port_wdata[0], 64'h0);
      check("midrst_port_be0", 64'(port_be[0]), 64'h0);
      check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
      port_rvalid[0] = 1'b1;
      port_rdata[0]  = 64'h1234;
      @(negedge clk);
      port_rvalid[0] = 1'b0;
      check("no_rsp_after_reset", 64'(rsp_valid), 64'h0);
      @(negedge clk);

      // Randomized rounds.
      for (int n = 0; n < 60; n++) begin
         set_req(0, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)));
         set_req(1, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)));
         run_round();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/carfield_l2_port_arbiter.md
CARFIELD_L2_PORT_ARBITER -- requirements
Module: carfield_l2_port_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 2, number of requesters sharing the dual-port L2.
REQ-002 The block SHALL have parameter AddrWidth, default 48, address width.
REQ-003 The block SHALL have parameter DataWidth, default 64, data width (byte enables DataWidth/8).
REQ-004 The block SHALL have parameter L2Base, default 'h7800_0000, base of L2 port 0; port 1 base is L2Base+L2PortSize.
REQ-005 The block SHALL have parameter L2PortSize, default 'h0020_0000, size of each L2 port window.
REQ-006 The block SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-007 The block SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-008 The block SHALL have port req_valid_i  in  [NumReq]  request valid per requester.
REQ-009 The block SHALL have port req_ready_o  out  [NumReq]  request accepted when valid&ready.
REQ-010 The block SHALL have port req_addr_i  in  [NumReq][AddrWidth]  absolute byte address.
REQ-011 The block SHALL have port req_we_i  in  [NumReq]  1=write, 0=read.
REQ-012 The block SHALL have port req_wdata_i  in  [NumReq][DataWidth]  write data.
REQ-013 The block SHALL have port req_be_i  in  [NumReq][DataWidth/8]  byte enables.
REQ-014 The block SHALL have port rsp_valid_o  out  [NumReq]  one-cycle response pulse, no back-pressure.
REQ-015 The block SHALL have port rsp_rdata_o  out  [NumReq][DataWidth]  read data (0 on write or error).
REQ-016 The block SHALL have port rsp_err_o  out  [NumReq]  decode error flag, qualified by rsp_valid_o.
REQ-017 The block SHALL have port port_req_o  out  [2]  L2 port request.
REQ-018 The block SHALL have port port_gnt_i  in  [2]  L2 port grant.
REQ-019 The block SHALL have port port_addr_o  out  [2][AddrWidth]  offset within port window (addr minus port base).
REQ-020 The block SHALL have ports port_we_o/port_wdata_o/port_be_o  out  [2][1/DataWidth/DataWidth/8]  latched request attributes.
REQ-021 The block SHALL have port port_rvalid_i  in  [2]  L2 port response valid.
REQ-022 The block SHALL have port port_rdata_i  in  [2][DataWidth]  L2 port read data.

Function
REQ-023 Decode SHALL be unsigned: [L2Base, L2Base+L2PortSize) -> port 0; [L2Base+L2PortSize, L2Base+2*L2PortSize) -> port 1; anything else -> decode error.
REQ-024 Each requester SHALL hold a busy flag, set on acceptance, cleared in the cycle its rsp_valid_o pulses; req_ready_o SHALL be 0 while busy, except in the rsp_valid_o cycle, where it is permitted to be 1.
REQ-025 Each port SHALL run FSM IDLE -> REQ (on acceptance) -> WAIT (on port_gnt_i while port_req_o=1) -> IDLE (on port_rvalid_i); acceptance for a port SHALL occur only in IDLE.
REQ-026 In REQ, port_req_o SHALL be 1 and port_addr_o/we/wdata/be SHALL stay stable until port_gnt_i; outside REQ, port_req_o SHALL be 0.
REQ-027 Per port, a round-robin pointer SHALL select, among non-busy valid requesters decoding to that port, the first index at or after the pointer; after a grant, the pointer SHALL become (winner+1) mod NumReq; only the winner sees req_ready_o=1.
REQ-028 Both ports SHALL accept independently in the same cycle; a requester SHALL be accepted by at most one port per cycle.
REQ-029 On port_rvalid_i in WAIT, the owner SHALL see rsp_valid_o=1, rsp_rdata_o=port_rdata_i (0 if write), rsp_err_o=0 in the following cycle (registered).
REQ-030 A non-busy decode-error request SHALL be accepted immediately without arbitration; the next cycle SHALL return rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, with no port activity.
REQ-031 port_rvalid_i in IDLE or REQ SHALL be ignored; port_gnt_i outside REQ SHALL be ignored.
REQ-032 Latency SHALL be: acceptance cycle N -> port_req_o in N+1; rvalid cycle M -> rsp_valid_o in M+1.

Reset
REQ-033 With rst_i=1 at a clock edge: all port FSMs IDLE, pointers 0, busy flags 0, port_req_o=0, rsp_valid_o=0, rsp_err_o=0, all data/address outputs 0.
REQ-034 Reset mid-transaction SHALL discard all outstanding requests; no response SHALL be issued for them after reset.

Verification
REQ-035 req0 read 'h7800_0010, gnt same cycle, rvalid 2 cycles later with 'hDEAD -> port_addr_o[0]='h10, rsp_valid_o[0] one cycle after rvalid, rdata 'hDEAD, err 0.
REQ-036 req1 write 'h7820_0008 -> port_req_o[1] with offset 'h8; port 0 idle; response rdata 0.
REQ-037 req0,req1 both to port 0 same cycle, pointer 0 -> req0 wins; repeat contention -> req1 wins.
REQ-038 req0 'h8000_0000 -> no port_req_o; next cycle rsp_err_o[0]=1, rdata 0.
REQ-039 req0->port 0, req1->port 1 same cycle -> both accepted, both port_req_o high next cycle.
REQ-040 rst_i asserted while port 0 in WAIT -> outputs cleared; later port_rvalid_i[0] produces no rsp_valid_o.
